blowfish128_decrypt_core: RTL and testbench

Decryption core for the Blowfish-128 datapath: takes a 128-bit ciphertext block and recovers the plaintext using 8 Feistel rounds on 64-bit halves, with the subkeys applied in reverse order. It sits beside the encryption core. It consumes the same 20×32-bit P-array from the subkey generator and shares the external F-function block over the X/Y request/acknowledge interface.

---
 rtl/blowfish128_pkg.sv | 35 +++
 rtl/blowfish128_decrypt_core_if.sv | 13 +
 rtl/blowfish128_decrypt_core.sv | 162 ++++++++++++++++
 tb/tb_blowfish128_decrypt_core.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/blowfish128_pkg.sv
// Shared constants, types and key-packing helper for the Blowfish-128 datapath.
package blowfish128_pkg;

    localparam int unsigned ROUNDS    = 8;
    localparam int unsigned KEY_WORDS = 20;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned HALF_W    = 64;
    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned RCNT_W    = 3;
    localparam int unsigned KIDX_W    = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ROUND_REQ = 3'd1,
        ROUND_ACK = 3'd2,
        WHITEN    = 3'd3,
        DONE      = 3'd4
    } dstate_t;

    // Word 0 holds P1, word 19 holds P20.
    typedef logic [KEY_WORDS-1:0][WORD_W-1:0] parray_t;

    typedef struct packed {
        logic [HALF_W-1:0] l;
        logic [HALF_W-1:0] r;
    } block_t;

    // K[j] = {P(2j+1), P(2j+2)}
    function automatic logic [HALF_W-1:0] pack_key(input parray_t p, input logic [KIDX_W-1:0] j);
        logic [4:0] idx;
        idx = {j, 1'b0};
        return {p[idx], p[idx + 5'd1]};
    endfunction

endpackage

// File: rtl/blowfish128_decrypt_core_if.sv
// Request/acknowledge link to the shared F-function block.
interface blowfish128_decrypt_core_if;
    import blowfish128_pkg::*;

    logic              ffunc_enable;
    logic [HALF_W-1:0] X;
    logic              ffunc_ready;
    logic [HALF_W-1:0] Y;

    modport master (output ffunc_enable, output X, input ffunc_ready, input Y);
    modport slave  (input ffunc_enable, input X, output ffunc_ready, output Y);

endinterface

// File: rtl/blowfish128_decrypt_core.sv
// Blowfish-128 decryption: 8 Feistel rounds on 64-bit halves with reversed subkeys,
// F-function evaluated externally over a 4-phase handshake.
module blowfish128_decrypt_core
    import blowfish128_pkg::*;
(
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 Start,
    input  logic [BLOCK_W-1:0]   cipherText,
    output logic [BLOCK_W-1:0]   plainText,
    output logic                 plainReady,
    output logic                 busy,
    input  logic                 skey_ready,
    input  logic [WORD_W-1:0]    P1,
    input  logic [WORD_W-1:0]    P2,
    input  logic [WORD_W-1:0]    P3,
    input  logic [WORD_W-1:0]    P4,
    input  logic [WORD_W-1:0]    P5,
    input  logic [WORD_W-1:0]    P6,
    input  logic [WORD_W-1:0]    P7,
    input  logic [WORD_W-1:0]    P8,
    input  logic [WORD_W-1:0]    P9,
    input  logic [WORD_W-1:0]    P10,
    input  logic [WORD_W-1:0]    P11,
    input  logic [WORD_W-1:0]    P12,
    input  logic [WORD_W-1:0]    P13,
    input  logic [WORD_W-1:0]    P14,
    input  logic [WORD_W-1:0]    P15,
    input  logic [WORD_W-1:0]    P16,
    input  logic [WORD_W-1:0]    P17,
    input  logic [WORD_W-1:0]    P18,
    input  logic [WORD_W-1:0]    P19,
    input  logic [WORD_W-1:0]    P20,
    blowfish128_decrypt_core_if.master ff
);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_ROUND_REQ = ROUND_REQ;
    localparam logic [2:0] ST_ROUND_ACK = ROUND_ACK;
    localparam logic [2:0] ST_WHITEN    = WHITEN;
    localparam logic [2:0] ST_DONE      = DONE;

    logic [2:0]        state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    parray_t           key_q, key_d;
    logic [HALF_W-1:0] lh_q, lh_d;
    logic [HALF_W-1:0] rh_q, rh_d;
    logic [HALF_W-1:0] x_q, x_d;
    logic              en_q, en_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    parray_t           p_in;
    block_t            ct;
    logic [HALF_W-1:0] rkey [ROUNDS];
    logic [RCNT_W-1:0] rcnt_inc;
    logic [HALF_W-1:0] rkey_next;

    assign p_in = {P20, P19, P18, P17, P16, P15, P14, P13, P12, P11,
                   P10, P9,  P8,  P7,  P6,  P5,  P4,  P3,  P2,  P1};
    assign ct   = cipherText;

    // Round-key table over K[2..9]; entry 7-r yields DK[r] = K[9-r].
    always_comb begin
        for (int unsigned i = 0; i < ROUNDS; i++) begin
            rkey[i] = pack_key(key_q, KIDX_W'(i + 2));
        end
        rcnt_inc  = rcnt_q + RCNT_W'(1);
        rkey_next = rkey[RCNT_W'(ROUNDS - 1) - rcnt_inc];
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        key_d   = key_q;
        lh_d    = lh_q;
        rh_d    = rh_q;
        x_d     = x_q;
        en_d    = en_q;
        done_d  = done_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start && skey_ready) begin
                    key_d   = p_in;
                    lh_d    = ct.l;
                    rh_d    = ct.r;
                    rcnt_d  = '0;
                    x_d     = ct.l ^ pack_key(p_in, KIDX_W'(9));
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = ST_ROUND_REQ;
                end
            end
            ST_ROUND_REQ: begin
                if (ff.ffunc_ready) begin
                    lh_d    = rh_q ^ ff.Y;
                    rh_d    = x_q;
                    en_d    = 1'b0;
                    state_d = ST_ROUND_ACK;
                end
            end
            ST_ROUND_ACK: begin
                // Next request only after the acknowledge has dropped.
                if (!ff.ffunc_ready) begin
                    if (rcnt_q != RCNT_W'(ROUNDS - 1)) begin
                        rcnt_d  = rcnt_inc;
                        x_d     = lh_q ^ rkey_next;
                        en_d    = 1'b1;
                        state_d = ST_ROUND_REQ;
                    end else begin
                        state_d = ST_WHITEN;
                    end
                end
            end
            ST_WHITEN: begin
                lh_d    = rh_q ^ pack_key(key_q, KIDX_W'(0));
                rh_d    = lh_q ^ pack_key(key_q, KIDX_W'(1));
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            key_q   <= '0;
            lh_q    <= '0;
            rh_q    <= '0;
            x_q     <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            key_q   <= key_d;
            lh_q    <= lh_d;
            rh_q    <= rh_d;
            x_q     <= x_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign plainText       = {lh_q, rh_q};
    assign plainReady      = done_q;
    assign busy            = busy_q;
    assign ff.ffunc_enable = en_q;
    assign ff.X            = x_q;

endmodule

// File: tb/tb_blowfish128_decrypt_core.sv
// Self-checking bench: F-function model, golden encryptor and result scoreboard.
module tb_blowfish128_decrypt_core;
    import blowfish128_pkg::*;

    logic         Clk = 1'b0;
    logic         RstN = 1'b0;
    logic         Start = 1'b0;
    logic         skey_ready = 1'b0;
    logic [127:0] cipherText = '0;
    logic [127:0] plainText;
    logic         plainReady;
    logic         busy;
    logic [31:0]  p [KEY_WORDS];

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] exp_q [$];

    int unsigned  f_mode = 0;
    bit           rand_dly = 1'b0;
    int unsigned  dly_tgt, dly_cnt;
    int unsigned  hs_viol = 0;
    logic         prev_en = 1'b0;
    logic [63:0]  prev_x = '0;

    blowfish128_decrypt_core_if ffi ();

    blowfish128_decrypt_core dut (
        .Clk(Clk), .RstN(RstN), .Start(Start), .cipherText(cipherText),
        .plainText(plainText), .plainReady(plainReady), .busy(busy), .skey_ready(skey_ready),
        .P1(p[0]),   .P2(p[1]),   .P3(p[2]),   .P4(p[3]),   .P5(p[4]),
        .P6(p[5]),   .P7(p[6]),   .P8(p[7]),   .P9(p[8]),   .P10(p[9]),
        .P11(p[10]), .P12(p[11]), .P13(p[12]), .P14(p[13]), .P15(p[14]),
        .P16(p[15]), .P17(p[16]), .P18(p[17]), .P19(p[18]), .P20(p[19]),
        .ff(ffi)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] f_ref(input logic [63:0] x);
        return {x[31:0], x[63:32]} + 64'h9E3779B97F4A7C15;
    endfunction

    function automatic logic [63:0] kw(input int j);
        return {p[2*j], p[2*j+1]};
    endfunction

    // Inverse of the decryption network, built from the round equations.
    function automatic logic [127:0] golden_enc(input logic [127:0] pt);
        logic [63:0] l, r, x;
        l = pt[63:0] ^ kw(1);
        r = pt[127:64] ^ kw(0);
        for (int rr = 7; rr >= 0; rr--) begin
            x = r;
            r = l ^ f_ref(x);
            l = x ^ kw(9 - rr);
        end
        return {l, r};
    endfunction

    // F-function: ready follows enable after 1 + dly_tgt cycles.
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            ffi.ffunc_ready <= 1'b0;
            ffi.Y           <= '0;
            dly_cnt         <= 0;
            dly_tgt         <= 0;
        end else if (ffi.ffunc_enable != ffi.ffunc_ready) begin
            if (dly_cnt >= dly_tgt) begin
                ffi.ffunc_ready <= ffi.ffunc_enable;
                if (ffi.ffunc_enable) ffi.Y <= (f_mode == 1) ? f_ref(ffi.X) : 64'h0;
                dly_cnt <= 0;
                dly_tgt <= rand_dly ? $urandom_range(9, 0) : 0;
            end else begin
                dly_cnt <= dly_cnt + 1;
            end
        end
    end

    // Handshake protocol monitor.
    always @(posedge Clk) begin
        if (RstN) begin
            if (ffi.ffunc_enable && !prev_en && ffi.ffunc_ready) hs_viol++;
            if (ffi.ffunc_enable && prev_en && ffi.X !== prev_x) hs_viol++;
        end
        prev_en = ffi.ffunc_enable;
        prev_x  = ffi.X;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rand_keys();
        for (int i = 0; i < KEY_WORDS; i++) p[i] = $urandom();
    endtask

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic launch(input logic [127:0] ct, input logic [127:0] expv);
        cipherText = ct;
        Start = 1'b1;
        exp_q.push_back(expv);
        step();
        Start = 1'b0;
    endtask

    // Wait for plainReady, compare against scoreboard head, optionally check latency.
    task automatic collect(input string tag, input int exp_lat);
        int cyc;
        logic [127:0] expv;
        cyc = 0;
        while (!plainReady && cyc < 3000) begin
            step();
            cyc++;
        end
        if (!plainReady) check({tag, "_timeout"}, 128'(plainReady), 128'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check(tag, plainText, expv);
        if (exp_lat >= 0) check({tag, "_latency"}, 128'(cyc), 128'(exp_lat));
    endtask

    initial begin
        logic [127:0] pt, ct, last_pt;

        for (int i = 0; i < KEY_WORDS; i++) p[i] = '0;
        repeat (3) step();
        check("rst_plainText", plainText, '0);
        check("rst_plainReady", 128'(plainReady), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_enable", 128'(ffi.ffunc_enable), 128'd0);
        check("rst_X", 128'(ffi.X), 128'd0);
        RstN = 1'b1;
        skey_ready = 1'b1;
        step();

        // Identity: zero F and zero keys reduce to the final half swap.
        f_mode = 0;
        launch(128'hAAAAAAAAAAAAAAAA_5555555555555555, 128'h5555555555555555_AAAAAAAAAAAAAAAA);
        check("busy_after_start", 128'(busy), 128'd1);
        check("enable_after_start", 128'(ffi.ffunc_enable), 128'd1);
        collect("identity", 33);
        check("busy_done", 128'(busy), 128'd0);

        // Whitening keys only.
        p[1] = 32'h1;
        p[3] = 32'h2;
        launch(128'hAAAAAAAAAAAAAAAA_5555555555555555, 128'h5555555555555554_AAAAAAAAAAAAAAA8);
        collect("whiten", 33);

        // Round trip on the reference block; keys scrambled after acceptance.
        f_mode = 1;
        rand_keys();
        pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
        launch(golden_enc(pt), pt);
        rand_keys();
        collect("roundtrip_ref", 33);
        last_pt = pt;

        // Start without valid subkeys is ignored.
        skey_ready = 1'b0;
        cipherText = rand_block();
        Start = 1'b1;
        step();
        Start = 1'b0;
        repeat (3) step();
        check("guard_skey_busy", 128'(busy), 128'd0);
        check("guard_skey_ready", 128'(plainReady), 128'd1);
        check("guard_skey_text", plainText, last_pt);
        skey_ready = 1'b1;

        // Start during round 3 is ignored.
        rand_keys();
        pt = rand_block();
        launch(golden_enc(pt), pt);
        repeat (13) step();
        rand_keys();
        cipherText = rand_block();
        Start = 1'b1;
        step();
        Start = 1'b0;
        collect("guard_midrun", -1);

        // Slow, randomly delayed F-function.
        rand_dly = 1'b1;
        for (int n = 0; n < 20; n++) begin
            rand_keys();
            pt = rand_block();
            launch(golden_enc(pt), pt);
            collect("handshake_rand", -1);
        end
        rand_dly = 1'b0;

        // Asynchronous reset during round 5, then a clean block.
        rand_keys();
        pt = rand_block();
        launch(golden_enc(pt), pt);
        repeat (21) step();
        RstN = 1'b0;
        #1;
        check("midrst_plainText", plainText, '0);
        check("midrst_plainReady", 128'(plainReady), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_enable", 128'(ffi.ffunc_enable), 128'd0);
        check("midrst_X", 128'(ffi.X), 128'd0);
        void'(exp_q.pop_front());
        step();
        RstN = 1'b1;
        step();
        rand_keys();
        pt = rand_block();
        launch(golden_enc(pt), pt);
        collect("after_reset", 33);

        // Bulk round trips with the reference F-model.
        for (int n = 0; n < 1000; n++) begin
            rand_keys();
            pt = rand_block();
            ct = golden_enc(pt);
            launch(ct, pt);
            collect("roundtrip_rand", 33);
        end

        check("handshake_violations", 128'(hs_viol), 128'd0);
        check("scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
